// File: rtl/alct_clct_match.sv
// ALCT/CLCT coincidence matcher: holds one ALCT for a MATCH_WIN-bx window and pairs it
// with the next CLCT, emitting one registered LCT term set per cycle for the quality encoder.
module alct_clct_match #(
  parameter int unsigned MATCH_WIN = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        alct_vpf,
  input  logic [2:0]  alct_nhit,
  input  logic        alct_accel,
  input  logic        clct_vpf,
  input  logic [2:0]  clct_nhit,
  input  logic [3:0]  clct_pat,
  output logic        lct_vpf,
  output logic        lct_a,
  output logic        lct_c,
  output logic        lct_a4,
  output logic        lct_c4,
  output logic        lct_cpat,
  output logic        lct_acc,
  output logic [3:0]  lct_p,
  output logic [3:0]  lct_bxoff,
  output logic [11:0] match_cnt
);

  localparam int unsigned WIN_W  = 4;
  localparam int unsigned NHIT_W = 3;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_W  = 12;

  typedef enum logic {IDLE, WINDOW} state_t;

  typedef struct packed {
    logic             vpf;
    logic             a;
    logic             c;
    logic             a4;
    logic             c4;
    logic             cpat;
    logic             acc;
    logic [PAT_W-1:0] p;
    logic [WIN_W-1:0] bxoff;
  } lct_t;

  state_t              state_q, state_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [NHIT_W-1:0]   hold_nhit_q, hold_nhit_d;
  logic                hold_acc_q, hold_acc_d;
  lct_t                lct_q, lct_d;
  logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
  logic                is_match;
  logic                clct_c4;
  logic                clct_cpat;
  logic                win_last;

  assign clct_c4   = (clct_nhit >= NHIT_W'(4));
  assign clct_cpat = (clct_pat >= PAT_W'(2)) && (clct_pat <= PAT_W'(10));
  assign win_last  = (win_cnt_q == WIN_W'(MATCH_WIN));

  // State, held ALCT and registered output payload
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      hold_nhit_q <= '0;
      hold_acc_q  <= 1'b0;
      lct_q       <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      hold_nhit_q <= hold_nhit_d;
      hold_acc_q  <= hold_acc_d;
      lct_q       <= lct_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  // Next-state and next-output decision; at most one LCT is built per cycle
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    hold_nhit_d = hold_nhit_q;
    hold_acc_d  = hold_acc_q;
    lct_d       = '0;
    is_match    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (alct_vpf && clct_vpf) begin
          is_match   = 1'b1;
          lct_d.vpf  = 1'b1;
          lct_d.a    = 1'b1;
          lct_d.c    = 1'b1;
          lct_d.a4   = (alct_nhit >= NHIT_W'(4));
          lct_d.c4   = clct_c4;
          lct_d.cpat = clct_cpat;
          lct_d.acc  = alct_accel;
          lct_d.p    = clct_pat;
        end else if (alct_vpf) begin
          hold_nhit_d = alct_nhit;
          hold_acc_d  = alct_accel;
          win_cnt_d   = WIN_W'(1);
          state_d     = WINDOW;
        end else if (clct_vpf) begin
          lct_d.vpf  = 1'b1;
          lct_d.c    = 1'b1;
          lct_d.c4   = clct_c4;
          lct_d.cpat = clct_cpat;
          lct_d.p    = clct_pat;
        end
      end

      WINDOW: begin
        if (clct_vpf) begin
          is_match    = 1'b1;
          lct_d.vpf   = 1'b1;
          lct_d.a     = 1'b1;
          lct_d.c     = 1'b1;
          lct_d.a4    = (hold_nhit_q >= NHIT_W'(4));
          lct_d.c4    = clct_c4;
          lct_d.cpat  = clct_cpat;
          lct_d.acc   = hold_acc_q;
          lct_d.p     = clct_pat;
          lct_d.bxoff = win_cnt_q;
        end else if (alct_vpf || win_last) begin
          // Held ALCT leaves unmatched: displaced by a new ALCT or window expired
          lct_d.vpf = 1'b1;
          lct_d.a   = 1'b1;
          lct_d.a4  = (hold_nhit_q >= NHIT_W'(4));
          lct_d.acc = hold_acc_q;
        end

        if (alct_vpf) begin
          hold_nhit_d = alct_nhit;
          hold_acc_d  = alct_accel;
          win_cnt_d   = WIN_W'(1);
        end else if (clct_vpf || win_last) begin
          win_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    match_cnt_d = match_cnt_q;
    if (is_match && (match_cnt_q != '1)) begin
      match_cnt_d = match_cnt_q + CNT_W'(1);
    end
  end

  assign lct_vpf   = lct_q.vpf;
  assign lct_a     = lct_q.a;
  assign lct_c     = lct_q.c;
  assign lct_a4    = lct_q.a4;
  assign lct_c4    = lct_q.c4;
  assign lct_cpat  = lct_q.cpat;
  assign lct_acc   = lct_q.acc;
  assign lct_p     = lct_q.p;
  assign lct_bxoff = lct_q.bxoff;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_alct_clct_match.sv
// Scoreboard bench for alct_clct_match: scenario tasks push expected LCTs (with due cycle),
// a negedge monitor pops and compares each strobe and flags missing or stray ones.
module tb_alct_clct_match;

  logic        clock;
  logic        reset_n;
  logic        alct_vpf;
  logic [2:0]  alct_nhit;
  logic        alct_accel;
  logic        clct_vpf;
  logic [2:0]  clct_nhit;
  logic [3:0]  clct_pat;
  logic        lct_vpf;
  logic        lct_a, lct_c, lct_a4, lct_c4, lct_cpat, lct_acc;
  logic [3:0]  lct_p;
  logic [3:0]  lct_bxoff;
  logic [11:0] match_cnt;

  alct_clct_match #(.MATCH_WIN(7)) dut (
    .clock(clock), .reset_n(reset_n),
    .alct_vpf(alct_vpf), .alct_nhit(alct_nhit), .alct_accel(alct_accel),
    .clct_vpf(clct_vpf), .clct_nhit(clct_nhit), .clct_pat(clct_pat),
    .lct_vpf(lct_vpf), .lct_a(lct_a), .lct_c(lct_c), .lct_a4(lct_a4), .lct_c4(lct_c4),
    .lct_cpat(lct_cpat), .lct_acc(lct_acc), .lct_p(lct_p), .lct_bxoff(lct_bxoff),
    .match_cnt(match_cnt)
  );

  // terms = {A, C, A4, C4, CPAT, ACC, P[3:0], BXOFF[3:0]}
  typedef struct {
    int          cyc;
    logic [13:0] terms;
    logic [11:0] mcnt;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          exp_mcnt = 0;
  logic [13:0] act;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  assign act = {lct_a, lct_c, lct_a4, lct_c4, lct_cpat, lct_acc, lct_p, lct_bxoff};

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (q.size() != 0 && q[0].cyc < cyc) begin
      tests++; fails++;
      $display("FAIL missing_lct: no strobe at cycle %0d, expected terms %h", q[0].cyc, q[0].terms);
      void'(q.pop_front());
    end
    if (lct_vpf === 1'b1) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        tests++; fails++;
        $display("FAIL unexpected_lct: lct_vpf=1 terms=%h at cycle %0d, expected lct_vpf=0", act, cyc);
      end else begin
        e = q.pop_front();
        tests++;
        if (act !== e.terms) begin
          fails++;
          $display("FAIL lct_terms: cycle %0d got %h expected %h", cyc, act, e.terms);
        end
        tests++;
        if (match_cnt !== e.mcnt) begin
          fails++;
          $display("FAIL match_cnt: cycle %0d got %0d expected %0d", cyc, match_cnt, e.mcnt);
        end
      end
    end else begin
      tests++;
      if (lct_vpf !== 1'b0 || act !== 14'd0) begin
        fails++;
        $display("FAIL idle_zero: cycle %0d lct_vpf=%b terms=%h expected 0/0", cyc, lct_vpf, act);
      end
    end
  end

  task automatic push(input int c, input logic [13:0] t, input bit is_match);
    exp_t r;
    if (is_match && exp_mcnt < 4095) exp_mcnt++;
    r.cyc = c; r.terms = t; r.mcnt = 12'(exp_mcnt);
    q.push_back(r);
  endtask

  task automatic pulse(input logic av, input logic [2:0] an, input logic aa,
                       input logic cv, input logic [2:0] cn, input logic [3:0] cp);
    alct_vpf = av; alct_nhit = an; alct_accel = aa;
    clct_vpf = cv; clct_nhit = cn; clct_pat = cp;
    @(posedge clock); #1;
    alct_vpf = 1'b0; alct_nhit = '0; alct_accel = 1'b0;
    clct_vpf = 1'b0; clct_nhit = '0; clct_pat = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    idle(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    alct_vpf = 1'b0; alct_nhit = '0; alct_accel = 1'b0;
    clct_vpf = 1'b0; clct_nhit = '0; clct_pat = '0;
    repeat (3) begin
      @(negedge clock);
      tests++;
      if (lct_vpf !== 1'b0 || act !== 14'd0 || match_cnt !== 12'd0) begin
        fails++;
        $display("FAIL reset_state: vpf=%b terms=%h cnt=%0d expected all 0", lct_vpf, act, match_cnt);
      end
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_match();
    int b = cyc;
    push(b + 4, {6'b111110, 4'd10, 4'd3}, 1'b1);
    pulse(1'b1, 3'd5, 1'b0, 1'b0, 3'd0, 4'd0);
    idle(2);
    pulse(1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 4'd10);
    drain();
    tests++;
    if (match_cnt !== 12'd1) begin
      fails++; $display("FAIL first_match_cnt: got %0d expected 1", match_cnt);
    end
  endtask

  task automatic test_expiry();
    int b = cyc;
    push(b + 8, {6'b100000, 4'd0, 4'd0}, 1'b0);
    pulse(1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 4'd0);
    drain();
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL expiry_drain: %0d pending, expected 0", q.size()); end
  endtask

  task automatic test_simul_idle();
    int b = cyc;
    push(b + 1, {6'b110101, 4'd1, 4'd0}, 1'b1);
    pulse(1'b1, 3'd2, 1'b1, 1'b1, 3'd4, 4'd1);
    drain();
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL simul_drain: %0d pending, expected 0", q.size()); end
  endtask

  task automatic test_clct_only();
    int b = cyc;
    push(b + 1, {6'b010010, 4'd2, 4'd0}, 1'b0);
    pulse(1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 4'd2);
    drain();
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL clct_only_drain: %0d pending, expected 0", q.size()); end
  endtask

  task automatic test_back_to_back();
    int b = cyc;
    push(b + 3, {6'b101001, 4'd0, 4'd0}, 1'b0);
    push(b + 5, {6'b110110, 4'd3, 4'd2}, 1'b1);
    pulse(1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 4'd0);
    idle(1);
    pulse(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 4'd0);
    idle(1);
    pulse(1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 4'd3);
    drain();
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL b2b_drain: %0d pending, expected 0", q.size()); end
  endtask

  task automatic test_window_edge();
    int b = cyc;
    push(b + 8, {6'b111011, 4'd7, 4'd7}, 1'b1);
    pulse(1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 4'd0);
    idle(6);
    pulse(1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 4'd7);
    drain();
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL edge_drain: %0d pending, expected 0", q.size()); end
  endtask

  task automatic test_window_simul();
    int b = cyc;
    push(b + 4,  {6'b111101, 4'd11, 4'd3}, 1'b1);
    push(b + 11, {6'b100000, 4'd0, 4'd0}, 1'b0);
    pulse(1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 4'd0);
    idle(2);
    pulse(1'b1, 3'd2, 1'b0, 1'b1, 3'd5, 4'd11);
    drain();
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL wsimul_drain: %0d pending, expected 0", q.size()); end
  endtask

  task automatic test_reset_mid_window();
    pulse(1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 4'd0);
    idle(1);
    reset_n = 1'b0;
    pulse(1'b1, 3'd6, 1'b0, 1'b1, 3'd6, 4'd5);
    idle(1);
    reset_n = 1'b1;
    exp_mcnt = 0;
    tests++;
    if (match_cnt !== 12'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
    push(cyc + 1, {6'b010100, 4'd12, 4'd0}, 1'b0);
    pulse(1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 4'd12);
    idle(12);
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL post_reset_drain: %0d pending, expected 0", q.size()); end
  endtask

  task automatic test_saturation();
    while (exp_mcnt < 4095) begin
      push(cyc + 1, {6'b111111, 4'd10, 4'd0}, 1'b1);
      pulse(1'b1, 3'd7, 1'b1, 1'b1, 3'd7, 4'd10);
    end
    push(cyc + 1, {6'b111111, 4'd10, 4'd0}, 1'b1);
    pulse(1'b1, 3'd7, 1'b1, 1'b1, 3'd7, 4'd10);
    drain();
    tests++;
    if (match_cnt !== 12'd4095) begin fails++; $display("FAIL saturate: got %0d expected 4095", match_cnt); end
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL sat_drain: %0d pending, expected 0", q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_match();
    test_expiry();
    test_simul_idle();
    test_clct_only();
    test_back_to_back();
    test_window_edge();
    test_window_simul();
    test_reset_mid_window();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
